// File: rtl/mimo_fifo_pkg.sv
// Shared helpers for the multi-in/multi-out FIFO: width derivation and modular pointer math.
package mimo_fifo_pkg;

    // Bits needed to hold a count in 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // ptr + inc wrapped into 0..depth-1, assuming ptr < depth and inc <= depth.
    function automatic int unsigned mod_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        int unsigned s;
        s = ptr + inc;
        return (s >= depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/mimo_fifo_ptr_add.sv
// Combinational modular adder: (ptr + inc) mod DEPTH for ptr < DEPTH, inc <= DEPTH.
module mimo_fifo_ptr_add #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PtrW  = 3
) (
    input  logic [PtrW-1:0] ptr_i,
    input  logic [PtrW:0]   inc_i,
    output logic [PtrW-1:0] sum_o
);

    localparam logic [PtrW+1:0] DEPTH_W = (PtrW+2)'(DEPTH);

    logic [PtrW+1:0] wide;

    // Operands are bounded so one conditional subtract always lands in range.
    assign wide  = {2'b00, ptr_i} + {1'b0, inc_i};
    assign sum_o = PtrW'((wide >= DEPTH_W) ? wide - DEPTH_W : wide);

endmodule

// File: rtl/mimo_fifo.sv
// Multi-in/multi-out FIFO with arbitrary depth and exact occupancy.
// Define MIMO_FIFO_STATS_EN to add sticky overflow/underflow flags and a usage watermark.
module mimo_fifo
    import mimo_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 2,
    parameter int unsigned PtrW       = ptr_width(DEPTH),
    parameter int unsigned CntW       = cnt_width(DEPTH),
    parameter int unsigned InCntW     = cnt_width(N_IN),
    parameter int unsigned OutCntW    = cnt_width(N_OUT)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  dtype [N_IN-1:0]         data_i,
    input  logic [InCntW-1:0]       push_cnt_i,
    output dtype [N_OUT-1:0]        data_o,
    input  logic [OutCntW-1:0]      pop_cnt_i,
    output logic [CntW-1:0]         usage_o,
    output logic [CntW-1:0]         free_o,
    output logic                    empty_o,
    output logic                    full_o,
`ifdef MIMO_FIFO_STATS_EN
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic [CntW-1:0]         watermark_o,
`endif
    output logic [OutCntW-1:0]      avail_o
);

    localparam logic [CntW:0] DEPTH_C = (CntW+1)'(DEPTH);
    localparam logic [CntW:0] N_IN_C  = (CntW+1)'(N_IN);
    localparam logic [CntW:0] N_OUT_C = (CntW+1)'(N_OUT);

    dtype                        mem_q [DEPTH];
    logic [PtrW-1:0]             rd_ptr_q, wr_ptr_q;
    logic [PtrW-1:0]             rd_ptr_n, wr_ptr_n;
    logic [CntW-1:0]             count_q;
    logic [CntW:0]               count_w, free_w, push_w, pop_w, count_n;
    logic                        push_acc, pop_acc;
    logic [N_IN-1:0][PtrW-1:0]   wr_addr;
    logic [N_OUT-1:0][PtrW-1:0]  rd_addr;

    assign count_w = {1'b0, count_q};
    assign free_w  = DEPTH_C - count_w;
    assign push_w  = (CntW+1)'(push_cnt_i);
    assign pop_w   = (CntW+1)'(pop_cnt_i);

    // Acceptance looks only at registered state: a same-cycle pop gives no push credit.
    assign push_acc = (push_w <= free_w);
    assign pop_acc  = (pop_w <= count_w);
    assign count_n  = count_w + (push_acc ? push_w : '0) - (pop_acc ? pop_w : '0);

    for (genvar k = 0; k < N_IN; k++) begin : g_wr_lane
        mimo_fifo_ptr_add #(.DEPTH(DEPTH), .PtrW(PtrW)) u_add (
            .ptr_i (wr_ptr_q),
            .inc_i ((PtrW+1)'(k)),
            .sum_o (wr_addr[k])
        );
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_rd_lane
        mimo_fifo_ptr_add #(.DEPTH(DEPTH), .PtrW(PtrW)) u_add (
            .ptr_i (rd_ptr_q),
            .inc_i ((PtrW+1)'(k)),
            .sum_o (rd_addr[k])
        );
        assign data_o[k] = mem_q[rd_addr[k]];
    end

    mimo_fifo_ptr_add #(.DEPTH(DEPTH), .PtrW(PtrW)) u_wr_next (
        .ptr_i (wr_ptr_q),
        .inc_i ((PtrW+1)'(push_cnt_i)),
        .sum_o (wr_ptr_n)
    );

    mimo_fifo_ptr_add #(.DEPTH(DEPTH), .PtrW(PtrW)) u_rd_next (
        .ptr_i (rd_ptr_q),
        .inc_i ((PtrW+1)'(pop_cnt_i)),
        .sum_o (rd_ptr_n)
    );

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!flush_i && push_acc) begin
            for (int k = 0; k < N_IN; k++) begin
                if (InCntW'(k) < push_cnt_i) mem_q[wr_addr[k]] <= data_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_n;
            if (pop_acc)  rd_ptr_q <= rd_ptr_n;
            count_q <= CntW'(count_n);
        end
    end

    assign usage_o = count_q;
    assign free_o  = CntW'(free_w);
    assign empty_o = (count_q == '0);
    assign full_o  = (free_w < N_IN_C);
    assign avail_o = (count_w < N_OUT_C) ? OutCntW'(count_q) : OutCntW'(N_OUT);

`ifdef MIMO_FIFO_STATS_EN
    logic            overflow_q, underflow_q;
    logic [CntW-1:0] watermark_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            watermark_q <= '0;
        end else if (flush_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            watermark_q <= '0;
        end else begin
            if (!push_acc)             overflow_q  <= 1'b1;
            if (!pop_acc)              underflow_q <= 1'b1;
            if (count_q > watermark_q) watermark_q <= count_q;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign watermark_o = watermark_q;
`endif

`ifndef SYNTHESIS
    // Rejections are legal traffic from the FIFO's point of view, so only warn.
    a_push_rejected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_i || push_acc)
        else $warning("mimo_fifo: push of %0d dropped, free %0d", push_cnt_i, free_w);

    a_pop_rejected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_i || pop_acc)
        else $warning("mimo_fifo: pop of %0d dropped, usage %0d", pop_cnt_i, count_q);

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_n <= DEPTH_C)
        else $error("mimo_fifo: next count %0d exceeds depth", count_n);
`endif

endmodule
